// File: rtl/data_mem_if.sv
// Data-memory bus between the pipeline (master) and data_mem_unit (slave).
interface data_mem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        Stall;
  logic        AddrError;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, ReadValid, Stall, AddrError
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, ReadValid, Stall, AddrError
  );
endinterface

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory: single-cycle stores, loads through IDLE/READ/DONE
// with READ_LATENCY wait cycles. Out-of-range, conflicting, and (optionally)
// misaligned requests are rejected with a one-cycle AddrError pulse.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject Address[1:0] != 0.
module data_mem_unit #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_WIDTH   = 12
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam int unsigned WORDS  = 1 << WIDX_W;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                aerr_q, aerr_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic                rbad_q, rbad_d;
  logic                wr_en_c;
  logic                addr_bad_c;
  logic [WIDX_W-1:0]   widx_c;
  logic [31:0]         mem_q [WORDS];

  // Word index of the current request.
  assign widx_c = bus.Address[ADDR_WIDTH-1:2];

  // Legality of the current request address.
`ifdef MEM_ALIGN_CHECK_EN
  assign addr_bad_c = (|bus.Address[31:ADDR_WIDTH]) | (|bus.Address[1:0]);
`else
  logic unused_lsb;
  assign unused_lsb = ^bus.Address[1:0];
  assign addr_bad_c = |bus.Address[31:ADDR_WIDTH];
`endif

  // Next-state, request decode and load completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    aerr_d   = 1'b0;
    widx_d   = widx_q;
    rbad_d   = rbad_q;
    wr_en_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MemRead && bus.MemWrite) begin
          aerr_d = 1'b1;
        end else if (bus.MemWrite) begin
          if (addr_bad_c) aerr_d = 1'b1;
          else            wr_en_c = 1'b1;
        end else if (bus.MemRead) begin
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          widx_d  = widx_c;
          rbad_d  = addr_bad_c;
          aerr_d  = addr_bad_c;
          state_d = READ;
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          rdata_d  = rbad_q ? 32'h0 : mem_q[widx_q];
          rvalid_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
      widx_q   <= '0;
      rbad_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      aerr_q   <= aerr_d;
      widx_q   <= widx_d;
      rbad_q   <= rbad_d;
    end
  end

  // Storage array; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && wr_en_c) mem_q[widx_c] <= bus.WriteData;
  end

  // Stall covers the request cycle of a load and every READ cycle.
  assign bus.Stall     = ((state_q == IDLE) && bus.MemRead && !bus.MemWrite) ||
                         (state_q == READ);
  assign bus.ReadData  = rdata_q;
  assign bus.ReadValid = rvalid_q;
  assign bus.AddrError = aerr_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench: three instances (READ_LATENCY 2, 1, 4) share one stimulus.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  int          total = 0;
  int          bad   = 0;

  data_mem_if if2 ();
  data_mem_if if1 ();
  data_mem_if if4 ();

  assign if2.MemRead = mem_read;  assign if2.MemWrite = mem_write;
  assign if2.Address = addr;      assign if2.WriteData = wdata;
  assign if1.MemRead = mem_read;  assign if1.MemWrite = mem_write;
  assign if1.Address = addr;      assign if1.WriteData = wdata;
  assign if4.MemRead = mem_read;  assign if4.MemWrite = mem_write;
  assign if4.Address = addr;      assign if4.WriteData = wdata;

  data_mem_unit #(.READ_LATENCY(2), .ADDR_WIDTH(12)) u2 (.clk(clk), .reset(reset), .bus(if2));
  data_mem_unit #(.READ_LATENCY(1), .ADDR_WIDTH(12)) u1 (.clk(clk), .reset(reset), .bus(if1));
  data_mem_unit #(.READ_LATENCY(4), .ADDR_WIDTH(12)) u4 (.clk(clk), .reset(reset), .bus(if4));

  always #5 clk = ~clk;

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [31:0] EXP_W4   = 32'hDEADBEEF;
  localparam logic        EXP_MISA = 1'b1;
`else
  localparam logic [31:0] EXP_W4   = 32'hCAFEF00D;
  localparam logic        EXP_MISA = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      mem_read = 1'b0; mem_write = 1'b0;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    cyc();
    mem_read = 1'b0; mem_write = 1'b1; addr = a; wdata = d;
    #1;
    chk("write_nostall", 32'(if2.Stall), 32'd0);
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    idle(2);
    #1;
    chk("rst_rdata",  if2.ReadData, 32'h0);
    chk("rst_rvalid", 32'(if2.ReadValid), 32'd0);
    chk("rst_aerr",   32'(if2.AddrError), 32'd0);
    chk("rst_stall",  32'(if2.Stall), 32'd0);
    reset = 1'b1;
    idle(1);

    // Store then load at latency 2 (and 1 on the second instance).
    do_write(32'h004, 32'hDEADBEEF);
    idle(1);
    cyc(); mem_read = 1'b1; addr = 32'h004; #1;
    chk("rd4_c0_stall2", 32'(if2.Stall), 32'd1);
    chk("rd4_c0_stall4", 32'(if4.Stall), 32'd1);
    cyc(); mem_read = 1'b0; #1;
    chk("rd4_c1_stall2",  32'(if2.Stall), 32'd1);
    chk("rd4_c1_rvalid2", 32'(if2.ReadValid), 32'd0);
    chk("rd4_c1_stall1",  32'(if1.Stall), 32'd1);
    cyc(); #1;
    chk("rd4_c2_stall2",  32'(if2.Stall), 32'd1);
    chk("rd4_c2_rvalid2", 32'(if2.ReadValid), 32'd0);
    chk("rd4_c2_rvalid1", 32'(if1.ReadValid), 32'd1);
    chk("rd4_c2_rdata1",  if1.ReadData, 32'hDEADBEEF);
    cyc(); #1;
    chk("rd4_c3_rvalid2", 32'(if2.ReadValid), 32'd1);
    chk("rd4_c3_rdata2",  if2.ReadData, 32'hDEADBEEF);
    chk("rd4_c3_stall2",  32'(if2.Stall), 32'd0);
    chk("rd4_c3_rvalid1", 32'(if1.ReadValid), 32'd0);
    cyc(); #1;
    chk("rd4_c4_rvalid2", 32'(if2.ReadValid), 32'd0);
    chk("rd4_c4_hold2",   if2.ReadData, 32'hDEADBEEF);
    cyc(); #1;
    chk("rd4_c5_rvalid4", 32'(if4.ReadValid), 32'd1);
    chk("rd4_c5_rdata4",  if4.ReadData, 32'hDEADBEEF);
    idle(2);

    // Latency-1 load of 0x00C.
    do_write(32'h00C, 32'h12345678);
    idle(1);
    cyc(); mem_read = 1'b1; addr = 32'h00C; #1;
    chk("rdC_c0_stall1", 32'(if1.Stall), 32'd1);
    cyc(); mem_read = 1'b0; #1;
    chk("rdC_c1_stall1",  32'(if1.Stall), 32'd1);
    chk("rdC_c1_rvalid1", 32'(if1.ReadValid), 32'd0);
    cyc(); #1;
    chk("rdC_c2_rvalid1", 32'(if1.ReadValid), 32'd1);
    chk("rdC_c2_rdata1",  if1.ReadData, 32'h12345678);
    chk("rdC_c2_stall1",  32'(if1.Stall), 32'd0);
    idle(5);

    // Simultaneous read and write is rejected.
    do_write(32'h010, 32'hA5A50010);
    idle(1);
    cyc(); mem_read = 1'b1; mem_write = 1'b1; addr = 32'h010; wdata = 32'hFFFFFFFF; #1;
    chk("both_c0_stall", 32'(if2.Stall), 32'd0);
    cyc(); mem_read = 1'b0; mem_write = 1'b0; #1;
    chk("both_c1_aerr",  32'(if2.AddrError), 32'd1);
    chk("both_c1_stall", 32'(if2.Stall), 32'd0);
    cyc(); #1;
    chk("both_c2_aerr",  32'(if2.AddrError), 32'd0);
    cyc(); mem_read = 1'b1; addr = 32'h010; #1;
    idle(2);
    cyc(); #1;
    chk("both_rb_rvalid", 32'(if2.ReadValid), 32'd1);
    chk("both_rb_rdata",  if2.ReadData, 32'hA5A50010);
    idle(4);

    // Out-of-range load returns zero with normal timing.
    cyc(); mem_read = 1'b1; addr = 32'h00001000; #1;
    chk("oob_c0_stall", 32'(if2.Stall), 32'd1);
    cyc(); mem_read = 1'b0; #1;
    chk("oob_c1_aerr",  32'(if2.AddrError), 32'd1);
    chk("oob_c1_stall", 32'(if2.Stall), 32'd1);
    cyc(); #1;
    chk("oob_c2_aerr",  32'(if2.AddrError), 32'd0);
    cyc(); #1;
    chk("oob_c3_rvalid", 32'(if2.ReadValid), 32'd1);
    chk("oob_c3_rdata",  if2.ReadData, 32'h0);
    idle(4);

    // Out-of-range store aliasing word 1 is suppressed.
    do_write(32'h00002004, 32'h0BADF00D);
    cyc(); mem_write = 1'b0; #1;
    chk("oobw_aerr", 32'(if2.AddrError), 32'd1);
    cyc(); mem_read = 1'b1; addr = 32'h004; #1;
    idle(2);
    cyc(); #1;
    chk("oobw_rdata", if2.ReadData, 32'hDEADBEEF);
    idle(4);

    // Misaligned store: rejected only with the alignment check built in.
    do_write(32'h006, 32'hCAFEF00D);
    cyc(); mem_write = 1'b0; #1;
    chk("misa_aerr", 32'(if2.AddrError), 32'(EXP_MISA));
    cyc(); mem_read = 1'b1; addr = 32'h004; #1;
    idle(2);
    cyc(); #1;
    chk("misa_rdata", if2.ReadData, EXP_W4);
    idle(4);

    // Reset in cycle 2 of a latency-4 load; a store under reset is dropped.
    cyc(); mem_read = 1'b1; addr = 32'h00C; #1;
    chk("rst_c0_stall4", 32'(if4.Stall), 32'd1);
    cyc(); mem_read = 1'b0; #1;
    cyc(); reset = 1'b0; #1;
    chk("rst_c2_stall4", 32'(if4.Stall), 32'd1);
    cyc(); mem_write = 1'b1; addr = 32'h00C; wdata = 32'hFFFFFFFF; #1;
    chk("rst_c3_rvalid4", 32'(if4.ReadValid), 32'd0);
    chk("rst_c3_stall4",  32'(if4.Stall), 32'd0);
    chk("rst_c3_rdata4",  if4.ReadData, 32'h0);
    chk("rst_c3_rvalid2", 32'(if2.ReadValid), 32'd0);
    cyc(); reset = 1'b1; mem_write = 1'b0; #1;
    for (int i = 4; i < 8; i++) begin
      chk("rst_no_rvalid4", 32'(if4.ReadValid), 32'd0);
      cyc(); #1;
    end
    mem_read = 1'b1; addr = 32'h00C;
    for (int i = 1; i <= 5; i++) begin
      cyc(); mem_read = 1'b0; #1;
      if (i == 3) begin
        chk("post_rst_rvalid2", 32'(if2.ReadValid), 32'd1);
        chk("post_rst_rdata2",  if2.ReadData, 32'h12345678);
      end
      if (i < 5) chk("post_rst_wait4", 32'(if4.ReadValid), 32'd0);
    end
    chk("post_rst_rvalid4", 32'(if4.ReadValid), 32'd1);
    chk("post_rst_rdata4",  if4.ReadData, 32'h12345678);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, number of wait cycles spent in READ (legal range 1..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, number of byte-address bits decoded (memory holds 2^(ADDR_WIDTH-2) 32-bit words).
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have MemRead  input  1  load request, held by the pipeline while Stall=1.
REQ-006 SHALL have MemWrite  input  1  store request.
REQ-007 SHALL have Address  input  32  byte address from the execute-stage ALU result.
REQ-008 SHALL have WriteData  input  32  store data.
REQ-009 SHALL have ReadData  output  32  registered load data.
REQ-010 SHALL have ReadValid  output  1  one-cycle pulse marking ReadData valid.
REQ-011 SHALL have Stall  output  1  pipeline freeze request.
REQ-012 SHALL have AddrError  output  1  one-cycle registered pulse flagging a rejected request.

Function
REQ-013 SHALL implement FSM states IDLE, READ and DONE.
REQ-014 SHALL sample requests only in IDLE and ignore MemRead/MemWrite in READ and DONE.
REQ-015 SHALL, in IDLE with MemWrite=1, MemRead=0 and a legal address, write WriteData to word Address[ADDR_WIDTH-1:2] at that edge, with no stall, and remain in IDLE.
REQ-016 SHALL, in IDLE with MemRead=1, MemWrite=0, load cnt=READ_LATENCY-1 and move to READ.
REQ-017 SHALL decrement cnt in READ on each edge; at the edge where cnt==0, register ReadData=mem[word], set ReadValid=1 and move to DONE.
REQ-018 SHALL in DONE hold ReadValid=1 for exactly one cycle and return to IDLE at the next edge with ReadValid=0.
REQ-019 SHALL drive Stall combinationally as (IDLE and MemRead and not MemWrite) or READ; Stall SHALL be 0 in DONE.
REQ-020 SHALL give load latency READ_LATENCY+1 cycles: request in cycle 0 -> ReadValid in cycle READ_LATENCY+1.
REQ-021 SHALL treat an address as illegal when Address[31:ADDR_WIDTH] is nonzero.
REQ-022 SHALL, for an illegal write, suppress the write and pulse AddrError in the following cycle.
REQ-023 SHALL, for an illegal read, follow normal FSM timing, return ReadData=0 and pulse AddrError in the cycle after acceptance.
REQ-024 SHALL, when MemRead and MemWrite are both 1 in IDLE, perform neither access, stay in IDLE, assert no Stall, and pulse AddrError next cycle.
REQ-025 SHALL leave ReadData unchanged except at read completion.

Reset
REQ-026 SHALL, when reset=0 at an edge, enter IDLE and set cnt=0, ReadData=0, ReadValid=0 and AddrError=0; Stall SHALL then follow REQ-019.
REQ-027 SHALL abort an in-flight read on reset, produce no ReadValid pulse for it, and leave memory contents unchanged.
REQ-028 SHALL perform no memory write at an edge where reset=0.

Configuration
REQ-029 SHALL, with macro MEM_ALIGN_CHECK_EN defined, treat Address[1:0]!=0 as illegal under REQ-021..REQ-023.
REQ-030 SHALL, without MEM_ALIGN_CHECK_EN defined, ignore Address[1:0] and decode only legal high-bit ranges.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to 0x004, then read 0x004 at READ_LATENCY=2 -> Stall high in cycles 0-2, ReadValid and ReadData=0xDEADBEEF in cycle 3.
REQ-032 SHALL cover: write 0x12345678 to 0x00C, then read 0x00C at READ_LATENCY=1 -> ReadValid in cycle 2 and ReadData=0x12345678.
REQ-033 SHALL cover: MemRead and MemWrite both 1 at 0x010 -> no Stall, AddrError pulse next cycle, and a later read of 0x010 returns the prior contents.
REQ-034 SHALL cover: read of 0x00001000 -> ReadData=0 with normal timing and AddrError pulse in cycle 1.
REQ-035 SHALL cover: reset=0 in cycle 2 of a READ_LATENCY=4 read -> IDLE, no ReadValid, and a subsequent read returns the pre-reset memory value.
REQ-036 SHALL cover: with MEM_ALIGN_CHECK_EN, write to 0x006 -> AddrError pulse and word 0x004 unchanged; without it, word 0x004 updated.
